// File: rtl/add32_seq.sv
// add32_seq: byte-serial adder/subtractor built around one 8-bit adder slice.
// An accepted request is processed one byte per clock, least significant
// byte first, so the result appears NBYTES edges after acceptance.
//
// Parameters:
//   NBYTES    operand width in bytes (2..8); W = 8*NBYTES
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  request present (op_a, op_b, sub, cin valid)
//   in_ready  block idle and able to accept a request
//   op_a      operand A
//   op_b      operand B
//   sub       0: A+B+cin, 1: A-B (cin ignored)
//   cin       carry-in for add mode
//   out_valid result, cout and ovf valid
//   out_ready consumer accepts the result
//   result    sum/difference modulo 2^W
//   cout      carry out of bit W-1 (sub mode: 1 = no borrow)
//   ovf       two's-complement signed overflow
//   busy      operation in progress or result pending
module add32_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;   // effective B: already inverted in sub mode

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [7:0]    s8;
  logic          c8;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Byte selection for the shared slice.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx == IW'(i)) begin
        a_byte = a_reg[i*8 +: 8];
        b_byte = b_reg[i*8 +: 8];
      end
    end
  end

  // The single 8-bit adder slice, shared across all byte cycles.
  always_comb begin
    {c8, s8} = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= op_a;
            b_reg <= op_b ^ {W{sub}};
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
              result[i*8 +: 8] <= s8;
            end
          end
          carry <= c8;
          if (idx == LAST_IDX) begin
            // On the top byte the slice MSBs are A[W-1], Beff[W-1], S[W-1].
            cout  <= c8;
            ovf   <= (a_byte[7] == b_byte[7]) && (s8[7] != a_byte[7]);
            // Index parked at 0 rather than stepping past NBYTES-1.
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add32_seq.sv
module tb_add32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_cmp;
  int n_err;

  add32_seq #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    int          hold;
    logic [31:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample point and drive point: 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed/unsigned whole-word arithmetic.
  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic c);
    longint sa, sb, st;
    logic [32:0] us;
    logic [31:0] r;
    logic co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = a - b;
      co = (a >= b);
      st = sa - sb;
    end else begin
      us = {1'b0, a} + {1'b0, b} + {32'b0, c};
      r  = us[31:0];
      co = us[32];
      st = sa + sb + longint'(c);
    end
    ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return {ov, co, r};
  endfunction

  // Full transaction: called at a drive point with the DUT idle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input int hold,
                        input logic [31:0] er, input logic eco, input logic eov);
    int edges;
    op_a = a; op_b = b; sub = s; cin = c;
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    step();  // accepting edge
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    edges = 0;
    while (!out_valid && edges < 10) begin
      chk({tag, " busy in RUN"}, 64'(busy), 64'd1);
      step();
      edges++;
      op_a = $urandom; op_b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    end
    chk({tag, " latency edges"}, 64'(edges), 64'd4);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " cout"}, 64'(cout), 64'(eco));
    chk({tag, " ovf"}, 64'(ovf), 64'(eov));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op_a = $urandom; op_b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      step();
      chk({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, " hold result/cout/ovf"}, {30'b0, ovf, cout, result}, {30'b0, eov, eco, er});
    end
    // in_valid stays high across the handshake edge; it must not be taken.
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    chk({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    chk({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    chk({tag, " busy after handshake"}, 64'(busy), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [33:0] m;
    logic [31:0] ra, rb;
    logic        rs, rc;
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, 3, 32'hDFD10457, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    step();
    step();
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result/cout/ovf", {30'b0, ovf, cout, result}, 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
             vecs[i].hold, vecs[i].r, vecs[i].co, vecs[i].ov);
    end

    // Reset after two byte cycles of RUN.
    op_a = 32'hAAAAAAAA; op_b = 32'h55555555; sub = 1'b0; cin = 1'b1;
    in_valid = 1'b1;
    step();  // accept
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort result/cout/ovf", {30'b0, ovf, cout, result}, 64'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("in reset out_valid", 64'(out_valid), 64'd0);
      chk("in reset busy", 64'(busy), 64'd0);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("post reset idle", 64'(busy), 64'd0);
    run_op("post_reset", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 0,
           32'h23456789, 1'b0, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      rc = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      if (i % 8 == 1) rb = ra;
      m = ref_model(ra, rb, rs, rc);
      run_op($sformatf("rand%0d", i), ra, rb, rs, rc, int'($urandom_range(0, 3)),
             m[31:0], m[32], m[33]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add32_seq.md
ADD32_SEQ -- requirements
Module: add32_seq

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes; legal range 2..8; W = 8*NBYTES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request present; operands and mode valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op_a  input  W  operand A.
REQ-007 op_b  input  W  operand B.
REQ-008 sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, initial carry 1, cin ignored).
REQ-009 cin  input  1  carry-in for add mode.
REQ-010 out_valid  output  1  result, cout and ovf are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  W  sum or difference, modulo 2^W.
REQ-013 cout  output  1  carry out of bit W-1; in sub mode 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The block SHALL contain exactly one combinational 8-bit adder slice (A8+B8+Cin -> S8, Cout), time-shared over NBYTES cycles; no wider adder SHALL be inferred.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = !IDLE.
REQ-018 IDLE: on in_valid&&in_ready, capture op_a, op_b ^ {W{sub}}, carry <= sub ? 1 : cin, byte index <= 0, go RUN; otherwise stay.
REQ-019 RUN, each cycle: feed byte[idx] of captured A and effective B plus the carry register to the slice; write S8 to result byte idx; carry <= slice Cout; idx <= idx+1.
REQ-020 RUN: on the cycle idx == NBYTES-1, additionally load cout <= slice Cout and ovf <= (A[W-1]==Beff[W-1]) && (S8[7]!=A[W-1]); go DONE.
REQ-021 Latency: out_valid SHALL rise exactly NBYTES clock edges after the accepting edge (4 for NBYTES=4); fixed, data-independent.
REQ-022 DONE: result, cout and ovf SHALL hold stable while out_ready is low; on out_ready high, go IDLE on that edge.
REQ-023 No overlap: in_valid SHALL be ignored in RUN and DONE; a new request is accepted no earlier than the cycle after the DONE handshake.
REQ-024 Changes on op_a, op_b, sub, cin after acceptance SHALL NOT affect the in-flight operation.
REQ-025 result bytes not yet written during RUN are don't-care; result is defined only when out_valid is high.
REQ-026 Byte index SHALL be ceil(log2(NBYTES)) bits; it SHALL never be used beyond NBYTES-1.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, byte index 0, carry 0, result 0, cout 0, ovf 0, out_valid 0, busy 0, in_ready 1, independent of clk.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation without emitting out_valid; no request is accepted while rst_n is low.
REQ-029 After rst_n deassertion the first accepted request SHALL complete correctly with no residue from the aborted operation.

Verification (NBYTES=4)
REQ-030 A=0x000000FF, B=0x00000001, sub=0, cin=0 -> result 0x00000100, cout 0, ovf 0; out_valid exactly 4 edges after accept.
REQ-031 A=0xFFFFFFFF, B=0x00000001, sub=0, cin=0 -> result 0x00000000, cout 1, ovf 0 (carry ripples through all 4 byte cycles).
REQ-032 A=0x7FFFFFFF, B=0x00000000, sub=0, cin=1 -> result 0x80000000, cout 0, ovf 1.
REQ-033 A=0x00000005, B=0x00000007, sub=1, cin=1 -> result 0xFFFFFFFE, cout 0, ovf 0; A=0x80000000, B=0x00000001, sub=1 -> 0x7FFFFFFF, cout 1, ovf 1.
REQ-034 Backpressure: out_ready low 3 cycles in DONE with in_valid high and new operands driven -> result/cout/ovf stable, in_ready 0, nothing accepted; out_ready high -> IDLE next edge, in_ready 1.
REQ-035 Reset mid-RUN after 2 byte cycles -> all outputs at reset values asynchronously, no out_valid; next request 0x12345678+0x11111111 -> 0x23456789, cout 0, ovf 0.
